mb_sequencer: RTL
=================

Name: mb_sequencer

Overview:
- Parametrised Math Box program sequencer; next generation of the fixed 8-bit load/increment program counter.
- Sits between the microcode latch/ROM decode and the Math Box microcode ROMs; drives the ROM address.
- Adds a hold mode, a subroutine call/return stack, selectable wrap or saturate at the top of the address space, and sticky error reporting.

Parameters:
- ADDR_W, 8, address width in bits (≥2).
- STACK_DEPTH, 4, return-stack entries (≥1; power of two not required).
- RESET_ADDR, 0, ROM_ADDR value after reset.
- WRAP_EN, 1, 1: increment wraps max→0; 0: increment saturates at max.

Ports:
- CLK  in  1  system clock, all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- ADDR_IN  in  ADDR_W  jump/call target.
- LOAD  in  1  load ADDR_IN into PC.
- CALL  in  1  push return address, jump to ADDR_IN.
- RET  in  1  pop stack into PC.
- INC_EN  in  1  increment PC.
- ERR_CLR  in  1  clear sticky error flags.
- ROM_ADDR  out  ADDR_W  registered program counter.
- WRAP  out  1  one-cycle pulse: the last update was an increment from max to 0.
- STACK_EMPTY  out  1  stack holds 0 entries.
- STACK_FULL  out  1  stack holds STACK_DEPTH entries.
- OVF  out  1  sticky: CALL was issued while full.
- UNF  out  1  sticky: RET was issued while empty.

Behaviour:
- Reset (async, asserted at any time, including mid-call): ROM_ADDR=RESET_ADDR, stack pointer=0, WRAP=0, OVF=0, UNF=0, STACK_EMPTY=1, STACK_FULL=0. Stack RAM contents are don't-care.
- Command priority per cycle is LOAD > CALL > RET > INC_EN > hold. Only the highest asserted command acts; the others are ignored with no side effects.
- Latency: all outputs are registered. A command sampled at edge N is visible on ROM_ADDR after edge N. There is no combinational path from any input to any output.
- LOAD: ROM_ADDR←ADDR_IN. The stack is untouched.
- CALL, not full:
  - push (ROM_ADDR+1) mod 2^ADDR_W;
  - ROM_ADDR←ADDR_IN;
  - pointer increments.
- CALL when full: no push, ROM_ADDR holds, OVF←1.
- RET, not empty: ROM_ADDR←top of stack; pointer decrements.
- RET when empty: ROM_ADDR holds, UNF←1.
- INC_EN:
  - ROM_ADDR←ROM_ADDR+1.
  - At max (all ones): if WRAP_EN=1, ROM_ADDR←0 and WRAP=1 for exactly one cycle. If WRAP_EN=0, ROM_ADDR holds at max and WRAP stays 0.
- Hold (no command): ROM_ADDR and stack are unchanged.
- WRAP is 0 in every cycle other than a wrapping increment.
- ERR_CLR clears OVF and UNF. If an error event and ERR_CLR occur in the same cycle, the error set wins.
- STACK_FULL and STACK_EMPTY are derived from the registered pointer. They are valid in the same cycle as the new ROM_ADDR.
- Stack pointer width is clog2(STACK_DEPTH+1). The pointer never exceeds STACK_DEPTH and never underflows.
- The stack is a LIFO; the return address stored is the PC value at the time of the CALL, plus one.

Decomposition:
- Shared package mb_pkg:
  - command-priority constants and localparam encodings for the internal op select (OP_HOLD, OP_INC, OP_RET, OP_CALL, OP_LOAD);
  - the stack-pointer width function.
- One sub-module, mb_return_stack: parametrised LIFO (ADDR_W × STACK_DEPTH) with push, pop, top, full and empty outputs, and async active-high reset of the pointer.
- The top level holds the op decode, the PC register, wrap/saturate logic and the sticky flags.

Test Plan:
- RESET pulse while INC_EN=1 and ROM_ADDR=0x37 → ROM_ADDR=0x00 immediately (async), STACK_EMPTY=1, OVF=UNF=0; increments resume on the first edge after release.
- ADDR_W=8, WRAP_EN=1: LOAD 0xFE, then INC_EN for 3 cycles → 0xFE, 0xFF, 0x00 (WRAP=1 this cycle only), 0x01.
- WRAP_EN=0: LOAD 0xFE, then INC_EN for 3 cycles → 0xFE, 0xFF, 0xFF, 0xFF, WRAP never asserted.
- Nested calls, STACK_DEPTH=4:
  - PC=0x10: CALL 0x40 → PC 0x40.
  - INC → 0x41.
  - CALL 0x80 → 0x80.
  - RET → 0x42.
  - RET → 0x11.
  - STACK_EMPTY=1 at the end.
- Stack overflow and underflow:
  - Fill with 4 CALLs; a 5th CALL 0xAA → PC unchanged, OVF=1, STACK_FULL=1.
  - Pop all 4; an extra RET → PC unchanged, UNF=1.
  - ERR_CLR → both flags 0.
  - A simultaneous ERR_CLR and bad RET → UNF remains 1.
- Priority: LOAD=CALL=RET=INC_EN=1 with ADDR_IN=0x5A → PC=0x5A, stack depth unchanged. Then CALL=RET=1 → PC=ADDR_IN and depth+1.

Source files
------------

// File: rtl/mb_pkg.sv
// mb_pkg: shared definitions for the Math Box program sequencer.
//   - op_t and the OP_* encodings of the per-cycle operation select
//   - decode_op(): picks one operation from the raw command inputs
//     (priority LOAD > CALL > RET > INC_EN > hold)
//   - sp_width() / idx_width(): widths of the return-stack pointer and RAM index
package mb_pkg;

  localparam int OP_W = 3;
  typedef logic [OP_W-1:0] op_t;

  // Encodings are ordered by priority: a larger value wins.
  localparam op_t OP_HOLD = 3'd0;
  localparam op_t OP_INC  = 3'd1;
  localparam op_t OP_RET  = 3'd2;
  localparam op_t OP_CALL = 3'd3;
  localparam op_t OP_LOAD = 3'd4;

  // Only the highest-priority asserted command is acted on.
  function automatic op_t decode_op(input logic load, input logic call,
                                    input logic ret, input logic inc);
    if (load)      return OP_LOAD;
    else if (call) return OP_CALL;
    else if (ret)  return OP_RET;
    else if (inc)  return OP_INC;
    else           return OP_HOLD;
  endfunction

  // The pointer must hold every value from 0 to depth (inclusive).
  function automatic int sp_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Index into the stack RAM; at least one bit even for a single entry.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mb_return_stack.sv
// mb_return_stack: LIFO of return addresses for the Math Box sequencer.
// Ports:
//   CLK        in   clock, rising edge
//   RESET      in   asynchronous active-high reset of the pointer
//   push       in   write push_data on top (ignored when full)
//   pop        in   discard the top entry (ignored when empty)
//   push_data  in   ADDR_W return address to store
//   top        out  ADDR_W current top entry (0 when empty)
//   full       out  STACK_DEPTH entries held
//   empty      out  no entries held
// full/empty/top depend only on registered state.
module mb_return_stack
  import mb_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              full,
  output logic              empty
);

  localparam int SP_W  = sp_width(STACK_DEPTH);
  localparam int IDX_W = idx_width(STACK_DEPTH);
  localparam logic [SP_W-1:0] DEPTH_V = SP_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0] ONE     = SP_W'(1);

  logic [SP_W-1:0]   sp;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              do_push;
  logic              do_pop;
  logic [ADDR_W-1:0] mem [STACK_DEPTH];

  assign full    = (sp == DEPTH_V);
  assign empty   = (sp == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // sp points at the next free slot; the top entry sits one below it.
  // Truncation is safe: writes only happen with sp < depth, reads with sp > 0.
  assign wr_idx = IDX_W'(sp);
  assign rd_idx = IDX_W'(sp - ONE);
  assign top    = empty ? '0 : mem[rd_idx];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sp <= '0;
    end else if (do_push) begin
      sp <= sp + ONE;
    end else if (do_pop) begin
      sp <= sp - ONE;
    end
  end

  // RAM contents are meaningless after reset, so no reset is needed here.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/mb_sequencer.sv
// mb_sequencer: Math Box microcode program sequencer (ROM address generator).
// Ports:
//   CLK          in   clock, rising edge
//   RESET        in   asynchronous active-high reset
//   ADDR_IN      in   ADDR_W jump/call target
//   LOAD         in   PC <= ADDR_IN
//   CALL         in   push PC+1, PC <= ADDR_IN
//   RET          in   PC <= popped return address
//   INC_EN       in   PC <= PC+1 (wrap or saturate at max)
//   ERR_CLR      in   clear OVF/UNF (an error in the same cycle wins)
//   ROM_ADDR     out  ADDR_W registered program counter
//   WRAP         out  one-cycle pulse after an increment from max to 0
//   STACK_EMPTY  out  return stack empty
//   STACK_FULL   out  return stack full
//   OVF          out  sticky: CALL while full
//   UNF          out  sticky: RET while empty
// Every output comes from a register; no input reaches an output combinationally.
module mb_sequencer
  import mb_pkg::*;
#(
  parameter int                ADDR_W      = 8,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
  parameter int                WRAP_EN     = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] ADDR_IN,
  input  logic              LOAD,
  input  logic              CALL,
  input  logic              RET,
  input  logic              INC_EN,
  input  logic              ERR_CLR,
  output logic [ADDR_W-1:0] ROM_ADDR,
  output logic              WRAP,
  output logic              STACK_EMPTY,
  output logic              STACK_FULL,
  output logic              OVF,
  output logic              UNF
);

  op_t               op;
  logic              push;
  logic              pop;
  logic              ovf_set;
  logic              unf_set;
  logic [ADDR_W-1:0] ret_addr;
  logic [ADDR_W-1:0] stk_top;
  logic [ADDR_W-1:0] pc_next;
  logic              wrap_next;

  mb_return_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .CLK       (CLK),
    .RESET     (RESET),
    .push      (push),
    .pop       (pop),
    .push_data (ret_addr),
    .top       (stk_top),
    .full      (STACK_FULL),
    .empty     (STACK_EMPTY)
  );

  // Return address wraps naturally at the top of the address space.
  assign ret_addr = ROM_ADDR + ADDR_W'(1);

  always_comb begin
    op        = decode_op(LOAD, CALL, RET, INC_EN);
    push      = (op == OP_CALL) && !STACK_FULL;
    pop       = (op == OP_RET) && !STACK_EMPTY;
    ovf_set   = (op == OP_CALL) && STACK_FULL;
    unf_set   = (op == OP_RET) && STACK_EMPTY;
    pc_next   = ROM_ADDR;
    wrap_next = 1'b0;
    case (op)
      OP_LOAD: pc_next = ADDR_IN;
      OP_CALL: if (!STACK_FULL)  pc_next = ADDR_IN;
      OP_RET:  if (!STACK_EMPTY) pc_next = stk_top;
      OP_INC: begin
        if (ROM_ADDR == '1) begin
          // Saturating build simply leaves pc_next at max.
          if (WRAP_EN != 0) begin
            pc_next   = '0;
            wrap_next = 1'b1;
          end
        end else begin
          pc_next = ROM_ADDR + ADDR_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ROM_ADDR <= RESET_ADDR;
      WRAP     <= 1'b0;
      OVF      <= 1'b0;
      UNF      <= 1'b0;
    end else begin
      ROM_ADDR <= pc_next;
      WRAP     <= wrap_next;
      // Setting takes precedence over a simultaneous clear.
      OVF      <= ovf_set | (OVF & ~ERR_CLR);
      UNF      <= unf_set | (UNF & ~ERR_CLR);
    end
  end

endmodule
